pcileech_cfgspace_arbiter: RTL and testbench

Schedules access to the 1024×32-bit shadow configuration-space BRAM for three requesters: PCIe TLP, USB/FIFO and internal logic. Separate, independent arbiters cover the write port and the read port. Losing requesters are held off with backpressure instead of being dropped. Each read completes after a fixed 2-cycle latency and is routed back to its originator with its tag intact. The block sits between the requester interfaces and the BRAM instance, inside the cfgspace shadow subsystem.

---
 rtl/pcileech_cfgarb_pkg.sv | 24 ++
 rtl/pcileech_cfgspace_arbiter_if.sv | 27 ++
 rtl/pcileech_cfgarb_pick.sv | 82 ++++++++
 rtl/pcileech_cfgspace_arbiter.sv | 118 +++++++++++
 tb/tb_pcileech_cfgspace_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_cfgarb_pkg.sv
// Shared types and constants for the cfgspace shadow BRAM arbiter.
package pcileech_cfgarb_pkg;

  localparam int unsigned NSRC        = 3;
  localparam int unsigned STARVE_MAX  = 15;
  localparam int unsigned BRAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    SRC_TLP = 2'd0,
    SRC_USB = 2'd1,
    SRC_INT = 2'd2
  } src_t;

  typedef struct packed {
    logic       valid;
    src_t       src;
    logic [7:0] tag;
  } rd_stage_t;

  function automatic logic [1:0] src_next(input logic [1:0] s);
    return (s == 2'(NSRC - 1)) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/pcileech_cfgspace_arbiter_if.sv
// Requester-side request/response bundle of pcileech_cfgspace_arbiter.
interface pcileech_cfgspace_arbiter_if;
  import pcileech_cfgarb_pkg::*;

  logic [NSRC-1:0]        req_valid;
  logic [NSRC-1:0]        req_ready;
  logic [NSRC-1:0]        req_wr;
  logic [NSRC-1:0][9:0]   req_addr;
  logic [NSRC-1:0][3:0]   req_be;
  logic [NSRC-1:0][31:0]  req_data;
  logic [NSRC-1:0][7:0]   req_tag;
  logic [NSRC-1:0]        rsp_valid;
  logic                   rsp_rd;
  logic [7:0]             rsp_tag;
  logic [31:0]            rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_be, req_data, req_tag,
    input  req_ready, rsp_valid, rsp_rd, rsp_tag, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_be, req_data, req_tag,
    output req_ready, rsp_valid, rsp_rd, rsp_tag, rsp_data
  );

endinterface

// File: rtl/pcileech_cfgarb_pick.sv
// One-of-NSRC picker. PCILEECH_CFGARB_RR_EN selects round-robin; otherwise
// fixed priority (lowest index first) with per-source starvation counters.
module pcileech_cfgarb_pick
  import pcileech_cfgarb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NSRC-1:0] valid_i,
  input  logic [NSRC-1:0] elig_i,
  output logic [NSRC-1:0] gnt_o,
  output logic [1:0]      idx_o,
  output logic            any_o
);

`ifdef PCILEECH_CFGARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic       unused_valid;

  assign unused_valid = ^valid_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = ptr_q;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!any_o && elig_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
      cand = src_next(cand);
    end
    gnt_o[idx_o] = any_o;
    ptr_d = any_o ? src_next(idx_o) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  logic [NSRC-1:0][3:0] cnt_q, cnt_d;

  // A starved source beats plain priority; lowest index wins among equals.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!any_o && elig_i[k] && (cnt_q[k] == 4'(STARVE_MAX))) begin
        any_o = 1'b1;
        idx_o = 2'(k);
      end
    end
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!any_o && elig_i[k]) begin
        any_o = 1'b1;
        idx_o = 2'(k);
      end
    end
    gnt_o[idx_o] = any_o;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (gnt_o[k]) begin
        cnt_d[k] = '0;
      end else if (valid_i[k] && (cnt_q[k] != 4'(STARVE_MAX))) begin
        cnt_d[k] = cnt_q[k] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule

// File: rtl/pcileech_cfgspace_arbiter.sv
// Write/read port arbiter for the 1024x32 cfgspace shadow BRAM.
// Arbitration policy is selected in the picker by PCILEECH_CFGARB_RR_EN.
module pcileech_cfgspace_arbiter
  import pcileech_cfgarb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  pcileech_cfgspace_arbiter_if.slave  bus,
  output logic [3:0]                  bram_wea,
  output logic [9:0]                  bram_addra,
  output logic [31:0]                 bram_dina,
  output logic [9:0]                  bram_addrb,
  input  logic [31:0]                 bram_doutb
);

  logic [NSRC-1:0] wr_valid, rd_valid, wr_elig, rd_elig, wr_gnt, rd_gnt;
  logic [1:0]      wr_idx, rd_idx;
  logic            wr_any, rd_any;
  logic            ack_fire;

  rd_stage_t [BRAM_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  rd_stage_t                   rd_out;
  rd_stage_t                   ack_q, ack_d;

  assign wr_valid = bus.req_valid & bus.req_wr;
  assign rd_valid = bus.req_valid & ~bus.req_wr;
  assign rd_out   = rd_pipe_q[BRAM_RD_LAT-1];
  assign ack_fire = ack_q.valid & ~rd_out.valid;
  // An ack that cannot drain this cycle still owns the single ack slot.
  assign wr_elig  = (ack_q.valid && rd_out.valid) ? '0 : wr_valid;

  pcileech_cfgarb_pick u_wr_pick (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (wr_valid),
    .elig_i  (wr_elig),
    .gnt_o   (wr_gnt),
    .idx_o   (wr_idx),
    .any_o   (wr_any)
  );

  always_comb begin
    bram_wea   = '0;
    bram_addra = '0;
    bram_dina  = '0;
    if (wr_any) begin
      bram_wea   = bus.req_be[wr_idx];
      bram_addra = bus.req_addr[wr_idx];
      bram_dina  = bus.req_data[wr_idx];
    end
  end

  // A read to the address being written this cycle waits, so it sees the new data.
  always_comb begin
    rd_elig = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      rd_elig[k] = rd_valid[k] && !(wr_any && (bus.req_addr[k] == bram_addra));
    end
  end

  pcileech_cfgarb_pick u_rd_pick (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (rd_valid),
    .elig_i  (rd_elig),
    .gnt_o   (rd_gnt),
    .idx_o   (rd_idx),
    .any_o   (rd_any)
  );

  assign bram_addrb    = rd_any ? bus.req_addr[rd_idx] : '0;
  assign bus.req_ready = wr_gnt | rd_gnt;

  always_comb begin
    rd_pipe_d          = rd_pipe_q;
    rd_pipe_d[0].valid = rd_any;
    rd_pipe_d[0].src   = src_t'(rd_idx);
    rd_pipe_d[0].tag   = rd_any ? bus.req_tag[rd_idx] : '0;
    for (int unsigned k = 1; k < BRAM_RD_LAT; k++) begin
      rd_pipe_d[k] = rd_pipe_q[k-1];
    end
    ack_d = ack_q;
    if (ack_fire) ack_d.valid = 1'b0;
    if (wr_any) begin
      ack_d.valid = 1'b1;
      ack_d.src   = src_t'(wr_idx);
      ack_d.tag   = bus.req_tag[wr_idx];
    end
  end

  // Read data owns the response slot; a colliding write ack waits in ack_q.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rd    = 1'b0;
    bus.rsp_tag   = '0;
    bus.rsp_data  = '0;
    if (rd_out.valid) begin
      bus.rsp_valid[rd_out.src] = 1'b1;
      bus.rsp_rd                = 1'b1;
      bus.rsp_tag               = rd_out.tag;
      bus.rsp_data              = bram_doutb;
    end else if (ack_q.valid) begin
      bus.rsp_valid[ack_q.src] = 1'b1;
      bus.rsp_tag              = ack_q.tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe_q <= '0;
      ack_q     <= '0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
      ack_q     <= ack_d;
    end
  end

endmodule

// File: tb/tb_pcileech_cfgspace_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the arbiter and a BRAM model.
module tb_pcileech_cfgspace_arbiter;
  import pcileech_cfgarb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcileech_cfgspace_arbiter_if bus ();
  logic [3:0]  bram_wea;
  logic [9:0]  bram_addra, bram_addrb;
  logic [31:0] bram_dina, bram_doutb;

  pcileech_cfgspace_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  // BRAM: byte-enabled write port A, port B with 2-cycle registered read.
  logic [31:0] bram [1024];
  logic [31:0] bram_s1;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bram_wea[b]) bram[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
    bram_s1    <= bram[bram_addrb];
    bram_doutb <= bram_s1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Pending request per source.
  logic [2:0]  p_v, p_wr;
  logic [9:0]  p_addr [3];
  logic [3:0]  p_be   [3];
  logic [31:0] p_data [3];
  logic [7:0]  p_tag  [3];

  // Reference model state.
  typedef struct {
    int          due;
    int          src;
    logic [7:0]  tag;
    logic [31:0] data;
  } exp_rsp_t;
  logic [31:0] m_mem [1024];
  exp_rsp_t    rdq [$];
  exp_rsp_t    ackq [$];
`ifdef PCILEECH_CFGARB_RR_EN
  int w_ptr, r_ptr;
`else
  int w_wait [3];
  int r_wait [3];
`endif

  logic [2:0]  log_ready [8192];
  logic [2:0]  log_rspv  [8192];
  logic        log_rd    [8192];
  logic [7:0]  log_tag   [8192];
  logic [31:0] log_data  [8192];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    rdq.delete();
    ackq.delete();
`ifdef PCILEECH_CFGARB_RR_EN
    w_ptr = 0;
    r_ptr = 0;
`else
    for (int s = 0; s < 3; s++) begin
      w_wait[s] = 0;
      r_wait[s] = 0;
    end
`endif
  endtask

  function automatic int pick(input logic [2:0] cand, input bit is_wr);
`ifdef PCILEECH_CFGARB_RR_EN
    int p = is_wr ? w_ptr : r_ptr;
    for (int k = 0; k < 3; k++) if (cand[(p + k) % 3]) return (p + k) % 3;
`else
    for (int k = 0; k < 3; k++)
      if (cand[k] && ((is_wr ? w_wait[k] : r_wait[k]) >= int'(STARVE_MAX))) return k;
    for (int k = 0; k < 3; k++) if (cand[k]) return k;
`endif
    return -1;
  endfunction

  task automatic issue(input int s, input bit wr, input logic [9:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [7:0] t);
    p_v[s]    = 1'b1;
    p_wr[s]   = wr;
    p_addr[s] = a;
    p_be[s]   = be;
    p_data[s] = d;
    p_tag[s]  = t;
  endtask

  task automatic drive();
    for (int s = 0; s < 3; s++) begin
      bus.req_valid[s] = p_v[s];
      bus.req_wr[s]    = p_wr[s];
      bus.req_addr[s]  = p_addr[s];
      bus.req_be[s]    = p_be[s];
      bus.req_data[s]  = p_data[s];
      bus.req_tag[s]   = p_tag[s];
    end
  endtask

  // One clock cycle: drive, predict from the rules, compare, advance.
  task automatic step_cycle();
    logic [2:0] wc, rc, e_ready, e_rspv;
    logic e_rd;
    logic [7:0] e_tag;
    logic [31:0] e_data, e_dina;
    logic [3:0] e_wea;
    logic [9:0] e_addra, e_addrb;
    int wg, rg, li;
    bit rd_now, ack_now, blk;
    exp_rsp_t e;
    drive();
    #2;
    rd_now  = (rdq.size() > 0) && (rdq[0].due == cyc);
    ack_now = !rd_now && (ackq.size() > 0);
    blk     = (ackq.size() > 0) && !ack_now;
    for (int s = 0; s < 3; s++) wc[s] = p_v[s] && p_wr[s] && !blk;
    wg = pick(wc, 1'b1);
    for (int s = 0; s < 3; s++)
      rc[s] = p_v[s] && !p_wr[s] && !((wg >= 0) && (p_addr[s] == p_addr[wg]));
    rg = pick(rc, 1'b0);
    e_ready = '0; e_wea = '0; e_addra = '0; e_dina = '0; e_addrb = '0;
    if (wg >= 0) begin
      e_ready[wg] = 1'b1;
      e_wea = p_be[wg]; e_addra = p_addr[wg]; e_dina = p_data[wg];
    end
    if (rg >= 0) begin
      e_ready[rg] = 1'b1;
      e_addrb = p_addr[rg];
    end
    e_rspv = '0; e_rd = 1'b0; e_tag = '0; e_data = '0;
    if (rd_now) begin
      e_rspv[rdq[0].src] = 1'b1; e_rd = 1'b1; e_tag = rdq[0].tag; e_data = rdq[0].data;
    end else if (ack_now) begin
      e_rspv[ackq[0].src] = 1'b1; e_tag = ackq[0].tag;
    end
    chk("req_ready", bus.req_ready, e_ready);
    chk("rsp_valid", bus.rsp_valid, e_rspv);
    chk("rsp_rd", bus.rsp_rd, e_rd);
    chk("rsp_tag", bus.rsp_tag, e_tag);
    chk("rsp_data", bus.rsp_data, e_data);
    chk("bram_wea", bram_wea, e_wea);
    chk("bram_addra", bram_addra, e_addra);
    chk("bram_dina", bram_dina, e_dina);
    chk("bram_addrb", bram_addrb, e_addrb);
    li = cyc % 8192;
    log_ready[li] = bus.req_ready;
    log_rspv[li]  = bus.rsp_valid;
    log_rd[li]    = bus.rsp_rd;
    log_tag[li]   = bus.rsp_tag;
    log_data[li]  = bus.rsp_data;
`ifdef PCILEECH_CFGARB_RR_EN
    if (wg >= 0) w_ptr = (wg + 1) % 3;
    if (rg >= 0) r_ptr = (rg + 1) % 3;
`else
    for (int s = 0; s < 3; s++) begin
      if (p_v[s] && p_wr[s])
        w_wait[s] = (s == wg) ? 0 : ((w_wait[s] < 15) ? w_wait[s] + 1 : w_wait[s]);
      if (p_v[s] && !p_wr[s])
        r_wait[s] = (s == rg) ? 0 : ((r_wait[s] < 15) ? r_wait[s] + 1 : r_wait[s]);
    end
`endif
    if (rd_now) void'(rdq.pop_front());
    if (ack_now) void'(ackq.pop_front());
    if (wg >= 0) begin
      for (int b = 0; b < 4; b++)
        if (p_be[wg][b]) m_mem[p_addr[wg]][8*b +: 8] = p_data[wg][8*b +: 8];
      e.due = cyc + 1; e.src = wg; e.tag = p_tag[wg]; e.data = '0;
      ackq.push_back(e);
      p_v[wg] = 1'b0;
    end
    if (rg >= 0) begin
      e.due = cyc + 2; e.src = rg; e.tag = p_tag[rg]; e.data = m_mem[p_addr[rg]];
      rdq.push_back(e);
      p_v[rg] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready"}, bus.req_ready, 0);
    chk({name, "_rspv"}, bus.rsp_valid, 0);
    chk({name, "_rd"}, bus.rsp_rd, 0);
    chk({name, "_tag"}, bus.rsp_tag, 0);
    chk({name, "_data"}, bus.rsp_data, 0);
    chk({name, "_wea"}, bram_wea, 0);
    chk({name, "_addra"}, bram_addra, 0);
    chk({name, "_dina"}, bram_dina, 0);
    chk({name, "_addrb"}, bram_addrb, 0);
  endtask

  initial begin
    int t0;
    rst = 1'b0;
    p_v = '0; p_wr = '0;
    for (int s = 0; s < 3; s++) begin
      p_addr[s] = '0; p_be[s] = '0; p_data[s] = '0; p_tag[s] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      bram[i]  = '0;
      m_mem[i] = '0;
    end
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Starvation: TLP writes every cycle, INT waits 15 cycles then wins.
    t0 = cyc;
    issue(2, 1'b1, 10'h200, 4'hF, 32'hC0DE_0002, 8'h92);
    for (int k = 0; k < 18; k++) begin
      if (!p_v[0]) issue(0, 1'b1, 10'(10'h100 + k), 4'hF, 32'h5000_0000 + k, 8'(k));
      step_cycle();
    end
    p_v = '0;
    repeat (3) step_cycle();
`ifndef PCILEECH_CFGARB_RR_EN
    chk("starve_tlp_14", log_ready[t0 + 14], 3'b001);
    chk("starve_int_15", log_ready[t0 + 15], 3'b100);
    chk("starve_tlp_16", log_ready[t0 + 16], 3'b001);
`endif

    // Three-way write collision.
    t0 = cyc;
    issue(0, 1'b1, 10'h010, 4'hF, 32'h1000_0010, 8'h10);
    issue(1, 1'b1, 10'h011, 4'hF, 32'h1000_0011, 8'h11);
    issue(2, 1'b1, 10'h012, 4'hF, 32'h1000_0012, 8'h12);
    repeat (5) step_cycle();
    chk("coll_gnt0", log_ready[t0], 3'b001);
    chk("coll_gnt1", log_ready[t0 + 1], 3'b010);
    chk("coll_gnt2", log_ready[t0 + 2], 3'b100);
    chk("coll_ack1", log_rspv[t0 + 1], 3'b001);
    chk("coll_ack2", log_rspv[t0 + 2], 3'b010);
    chk("coll_ack3", log_rspv[t0 + 3], 3'b100);
    for (int k = 0; k < 3; k++) begin
      t0 = cyc;
      issue(2, 1'b0, 10'(10'h010 + k), 4'h0, 32'h0, 8'(8'h20 + k));
      repeat (3) step_cycle();
      chk("coll_rdback", log_data[t0 + 2], 32'h1000_0010 + k);
    end

    // Write hazard: same-cycle read of the address being written waits one cycle.
    t0 = cyc;
    issue(0, 1'b1, 10'h004, 4'hF, 32'hDEAD_BEEF, 8'h31);
    issue(1, 1'b0, 10'h004, 4'h0, 32'h0, 8'h42);
    repeat (5) step_cycle();
    chk("haz_gnt0", log_ready[t0], 3'b001);
    chk("haz_gnt1", log_ready[t0 + 1], 3'b010);
    chk("haz_rspv", log_rspv[t0 + 3], 3'b010);
    chk("haz_data", log_data[t0 + 3], 32'hDEAD_BEEF);
    chk("haz_tag", log_tag[t0 + 3], 8'h42);

    // Read latency.
    t0 = cyc;
    issue(2, 1'b0, 10'h3FF, 4'h0, 32'h0, 8'h5A);
    repeat (4) step_cycle();
    chk("lat_gnt", log_ready[t0], 3'b100);
    chk("lat_early", log_rspv[t0 + 1], 3'b000);
    chk("lat_rspv", log_rspv[t0 + 2], 3'b100);
    chk("lat_tag", log_tag[t0 + 2], 8'h5A);
    chk("lat_rd", log_rd[t0 + 2], 1'b1);

    // Ack/read clash: read at n-1, write at n, another writer waiting.
    t0 = cyc;
    issue(1, 1'b0, 10'h011, 4'h0, 32'h0, 8'h61);
    step_cycle();
    issue(0, 1'b1, 10'h030, 4'hF, 32'hA5A5_0030, 8'h62);
    issue(2, 1'b1, 10'h031, 4'hF, 32'hA5A5_0031, 8'h63);
    repeat (5) step_cycle();
    chk("clash_wgnt_n", log_ready[t0 + 1], 3'b001);
    chk("clash_rd_n1", log_rspv[t0 + 2], 3'b010);
    chk("clash_rdflag_n1", log_rd[t0 + 2], 1'b1);
    chk("clash_noGnt_n1", log_ready[t0 + 2], 3'b000);
    chk("clash_ack_n2", log_rspv[t0 + 3], 3'b001);
    chk("clash_acktag_n2", log_tag[t0 + 3], 8'h62);
    chk("clash_int_n2", log_ready[t0 + 3], 3'b100);

    // Random traffic over a small address window to provoke hazards and clashes.
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (!p_v[s] && ($urandom_range(0, 99) < 65)) begin
          issue(s, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7)),
                4'($urandom), $urandom, 8'($urandom));
        end
      end
      step_cycle();
    end
    p_v = '0;
    repeat (6) step_cycle();

    // Reset with a read in flight and a write ack pending.
    issue(2, 1'b0, 10'h3FF, 4'h0, 32'h0, 8'h77);
    issue(0, 1'b1, 10'h020, 4'hF, 32'h1234_5678, 8'h78);
    step_cycle();
    p_v = '0;
    drive();
    rst = 1'b0;
    model_reset();
    #2;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_cycle();
      chk("postrst_norsp", log_rspv[(cyc - 1) % 8192], 3'b000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
